dp_instr_sequencer: RTL and testbench

Programmable instruction sequencer for the R-type datapath (32-bit `instruccion_r` in, `tr_zf` out).
- Holds a small program memory loaded over a write port.
- On `start`, issues each instruction to the datapath in order and holds it stable for a configurable number of cycles.
- Strobes a commit cycle, records the zero flag per instruction and signals completion.
- Replaces the fixed-delay stimulus sequence with a synthesizable controller.

---
 rtl/dp_pkg.sv | 27 ++
 rtl/dp_prog_mem.sv | 25 ++
 rtl/dp_instr_sequencer.sv | 130 +++++++++++++
 tb/tb_dp_instr_sequencer.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dp_pkg.sv
// Shared types and constants for the R-type datapath instruction sequencer.
package dp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_COMMIT = 2'd2,
        ST_DONE   = 2'd3
    } seq_state_t;

    // R-type instruction field positions
    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 26;
    localparam int RS_MSB     = 25;
    localparam int RS_LSB     = 21;
    localparam int RT_MSB     = 20;
    localparam int RT_LSB     = 16;
    localparam int RD_MSB     = 15;
    localparam int RD_LSB     = 11;
    localparam int SHAMT_MSB  = 10;
    localparam int SHAMT_LSB  = 6;
    localparam int FUNCT_MSB  = 5;
    localparam int FUNCT_LSB  = 0;

    localparam logic [31:0] NOP_WORD = 32'h0;

endpackage

// File: rtl/dp_prog_mem.sv
// Program store: DEPTH x 32 words, synchronous write, asynchronous read.
// Not reset, so a loaded program survives a sequencer reset.
module dp_prog_mem #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [31:0]       wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [31:0]       rdata
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/dp_instr_sequencer.sv
// Issues a loaded program to the datapath, holding each word HOLD_CYCLES cycles then
// strobing one commit cycle; pause stalls the hold count, start/prog_we are ignored unless idle.
module dp_instr_sequencer
    import dp_pkg::*;
#(
    parameter int DEPTH       = 16,
    parameter int ADDR_W      = 4,
    parameter int HOLD_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [31:0]       prog_data,
    input  logic [ADDR_W:0]   prog_len,
    input  logic              start,
    input  logic              pause,
    output logic [31:0]       instruccion_r,
    output logic              dp_commit,
    input  logic              tr_zf,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W:0]   zf_count,
    output logic [DEPTH-1:0]  zf_log
);

    localparam logic [3:0]        HOLD_LOAD = 4'(HOLD_CYCLES - 1);
    localparam logic [ADDR_W:0]   LEN_ONE   = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] PC_ONE    = ADDR_W'(1);

    seq_state_t        state, state_nxt;
    logic [3:0]        hold_cnt;
    logic [ADDR_W:0]   len;
    logic [ADDR_W-1:0] rd_addr;
    logic [31:0]       rd_dat;
    logic [31:0]       first_word;
    logic              mem_we;
    logic              last_instr;

    assign mem_we     = prog_we && (state == ST_IDLE);
    assign rd_addr    = (state == ST_IDLE) ? '0 : pc + PC_ONE;
    assign last_instr = ({1'b0, pc} + LEN_ONE) == len;
    // Forward a same-cycle write to address 0 so start sees the new word.
    assign first_word = (prog_we && (prog_addr == '0)) ? prog_data : rd_dat;

    dp_prog_mem #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_prog_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (prog_addr),
        .wdata (prog_data),
        .raddr (rd_addr),
        .rdata (rd_dat)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (start) state_nxt = (prog_len == '0) ? ST_DONE : ST_ISSUE;
            ST_ISSUE:  if (!pause && (hold_cnt == '0)) state_nxt = ST_COMMIT;
            ST_COMMIT: state_nxt = last_instr ? ST_DONE : ST_ISSUE;
            ST_DONE:   state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        busy      = (state == ST_ISSUE) || (state == ST_COMMIT);
        dp_commit = (state == ST_COMMIT);
        done      = (state == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            instruccion_r <= NOP_WORD;
            pc            <= '0;
            zf_count      <= '0;
            zf_log        <= '0;
            hold_cnt      <= '0;
            len           <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        len      <= prog_len;
                        zf_count <= '0;
                        zf_log   <= '0;
                        if (prog_len != '0) begin
                            pc            <= '0;
                            instruccion_r <= first_word;
                            hold_cnt      <= HOLD_LOAD;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (!pause && (hold_cnt != '0)) begin
                        hold_cnt <= hold_cnt - 4'd1;
                    end
                end
                ST_COMMIT: begin
                    zf_log[pc] <= tr_zf;
                    zf_count   <= zf_count + {{ADDR_W{1'b0}}, tr_zf};
                    if (!last_instr) begin
                        pc            <= pc + PC_ONE;
                        instruccion_r <= rd_dat;
                        hold_cnt      <= HOLD_LOAD;
                    end
                end
                ST_DONE: begin
                    instruccion_r <= NOP_WORD;
                end
                default: begin
                    instruccion_r <= NOP_WORD;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dp_instr_sequencer.sv
// Directed and randomized runs of the sequencer against a per-instruction timeline model.
module tb_dp_instr_sequencer;
    import dp_pkg::*;

    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;
    localparam int HOLD   = 2;
    localparam int NS     = 1024;

    logic              clk = 1'b0;
    logic              rst, prog_we, start, pause, tr_zf;
    logic [ADDR_W-1:0] prog_addr;
    logic [31:0]       prog_data;
    logic [ADDR_W:0]   prog_len;
    logic [31:0]       instruccion_r;
    logic              dp_commit, busy, done;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W:0]   zf_count;
    logic [DEPTH-1:0]  zf_log;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dp_instr_sequencer #(
        .DEPTH       (DEPTH),
        .ADDR_W      (ADDR_W),
        .HOLD_CYCLES (HOLD)
    ) u_dut (
        .clk           (clk),
        .rst           (rst),
        .prog_we       (prog_we),
        .prog_addr     (prog_addr),
        .prog_data     (prog_data),
        .prog_len      (prog_len),
        .start         (start),
        .pause         (pause),
        .instruccion_r (instruccion_r),
        .dp_commit     (dp_commit),
        .tr_zf         (tr_zf),
        .busy          (busy),
        .done          (done),
        .pc            (pc),
        .zf_count      (zf_count),
        .zf_log        (zf_log)
    );

    // Reference: program contents plus the expected cycle-by-cycle view of one run.
    logic [31:0] ref_mem [DEPTH];
    bit          p_seq [NS];
    bit          z_seq [NS];
    logic [31:0] e_instr [NS];
    bit          e_commit [NS];
    bit          e_busy [NS];
    bit          e_done [NS];
    int          e_pc [NS];
    int          c_at [DEPTH];
    int          n_cyc;
    int          run_len;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load(input int a, input logic [31:0] d);
        prog_we   = 1'b1;
        prog_addr = ADDR_W'(a);
        prog_data = d;
        @(posedge clk); #1;
        prog_we   = 1'b0;
        ref_mem[a] = d;
    endtask

    task automatic gen_seq(input int pause_pct);
        for (int i = 0; i < NS; i++) begin
            p_seq[i] = (i < 900) && ($urandom_range(99) < pause_pct);
            z_seq[i] = 1'($urandom_range(1));
        end
    endtask

    task automatic put(input int s, input logic [31:0] ins, input bit cm, input bit bz,
                       input bit dn, input int p);
        e_instr[s]  = ins;
        e_commit[s] = cm;
        e_busy[s]   = bz;
        e_done[s]   = dn;
        e_pc[s]     = p;
    endtask

    // Each instruction needs HOLD unpaused issue cycles, then one commit cycle.
    task automatic build(input int len);
        int s;
        int got;
        s = 1;
        run_len = len;
        for (int k = 0; k < len; k++) begin
            got = 0;
            while (got < HOLD) begin
                put(s, ref_mem[k], 1'b0, 1'b1, 1'b0, k);
                if (!p_seq[s]) got++;
                s++;
            end
            c_at[k] = s;
            put(s, ref_mem[k], 1'b1, 1'b1, 1'b0, k);
            s++;
        end
        n_cyc = s;
        put(s,     (len > 0) ? ref_mem[len-1] : 32'h0, 1'b0, 1'b0, 1'b1, (len > 0) ? len - 1 : -1);
        put(s + 1, 32'h0,                              1'b0, 1'b0, 1'b0, (len > 0) ? len - 1 : -1);
    endtask

    task automatic run(input int rst_at, input bit poke, output int done_seen);
        logic [DEPTH-1:0] exp_log;
        int               exp_cnt;
        prog_len = (ADDR_W+1)'(run_len);
        start    = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
        prog_we  = 1'b0;
        done_seen = -1;
        for (int s = 1; s <= n_cyc + 1; s++) begin
            pause = p_seq[s];
            tr_zf = z_seq[s];
            if (poke && s == 2) begin
                start     = 1'b1;
                prog_we   = 1'b1;
                prog_addr = ADDR_W'($urandom);
                prog_data = $urandom;
            end
            if (s == 3) begin
                start   = 1'b0;
                prog_we = 1'b0;
            end
            rst = (s == rst_at);
            chk("instr", 64'(instruccion_r), 64'(e_instr[s]));
            chk("commit", 64'(dp_commit), 64'(e_commit[s]));
            chk("busy", 64'(busy), 64'(e_busy[s]));
            chk("done", 64'(done), 64'(e_done[s]));
            if (e_pc[s] >= 0) chk("pc", 64'(pc), 64'(e_pc[s]));
            if (done && done_seen < 0) done_seen = s;
            @(posedge clk); #1;
            if (s == rst_at) begin
                rst = 1'b0;
                chk("rst_instr", 64'(instruccion_r), 64'h0);
                chk("rst_commit", 64'(dp_commit), 64'h0);
                chk("rst_busy", 64'(busy), 64'h0);
                chk("rst_done", 64'(done), 64'h0);
                chk("rst_pc", 64'(pc), 64'h0);
                chk("rst_zfcnt", 64'(zf_count), 64'h0);
                chk("rst_zflog", 64'(zf_log), 64'h0);
                pause = 1'b0;
                return;
            end
        end
        pause   = 1'b0;
        start   = 1'b0;
        prog_we = 1'b0;
        exp_log = '0;
        exp_cnt = 0;
        for (int k = 0; k < run_len; k++) begin
            exp_log[k] = z_seq[c_at[k]];
            exp_cnt   += int'(z_seq[c_at[k]]);
        end
        chk("zf_log", 64'(zf_log), 64'(exp_log));
        chk("zf_count", 64'(zf_count), 64'(exp_cnt));
    endtask

    initial begin
        int dseen;
        int len;
        int a;
        rst = 1'b1; prog_we = 1'b0; start = 1'b0; pause = 1'b0; tr_zf = 1'b0;
        prog_addr = '0; prog_data = '0; prog_len = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_instr", 64'(instruccion_r), 64'h0);
        chk("reset_commit", 64'(dp_commit), 64'h0);
        chk("reset_busy", 64'(busy), 64'h0);
        chk("reset_done", 64'(done), 64'h0);
        chk("reset_pc", 64'(pc), 64'h0);
        chk("reset_zfcnt", 64'(zf_count), 64'h0);
        chk("reset_zflog", 64'(zf_log), 64'h0);
        rst = 1'b0;

        // Three-word program, zero flag 1,0,1 on the commits.
        load(0, 32'h00A10000);
        load(1, 32'h00C45000);
        load(2, 32'h01272001);
        gen_seq(0);
        build(3);
        z_seq[c_at[0]] = 1'b1;
        z_seq[c_at[1]] = 1'b0;
        z_seq[c_at[2]] = 1'b1;
        run(-1, 1'b0, dseen);
        chk("t1_done_cycle", 64'(dseen), 64'd10);
        chk("t1_pc", 64'(pc), 64'd2);
        chk("t2_zf_log", 64'(zf_log), 64'h0005);
        chk("t2_zf_count", 64'(zf_count), 64'd2);

        // Pause held for five cycles while instruction 1 is issued.
        gen_seq(0);
        for (int s = 4; s <= 8; s++) p_seq[s] = 1'b1;
        build(3);
        run(-1, 1'b0, dseen);
        chk("t3_done_cycle", 64'(dseen), 64'd15);

        // Empty program, then a full-depth program.
        gen_seq(20);
        build(0);
        run(-1, 1'b0, dseen);
        chk("t4_len0_done", 64'(dseen), 64'd1);
        for (int i = 0; i < DEPTH; i++) load(i, $urandom);
        gen_seq(25);
        build(DEPTH);
        run(-1, 1'b0, dseen);
        chk("t4_len16_pc", 64'(pc), 64'd15);

        // Start and write pulsed mid-run; the following full run reads the memory back.
        gen_seq(20);
        build($urandom_range(3, DEPTH));
        run(-1, 1'b1, dseen);
        gen_seq(10);
        build(DEPTH);
        run(-1, 1'b0, dseen);

        // Reset during the commit of instruction 1, then a clean rerun.
        gen_seq(25);
        build(4);
        run(c_at[1], 1'b0, dseen);
        gen_seq(25);
        build(4);
        run(-1, 1'b0, dseen);

        // Random lengths, pauses and same-cycle writes alongside start.
        for (int r = 0; r < 6; r++) begin
            len = $urandom_range(1, DEPTH);
            if ($urandom_range(1) == 1) begin
                a         = $urandom_range(0, DEPTH - 1);
                prog_we   = 1'b1;
                prog_addr = ADDR_W'(a);
                prog_data = $urandom;
                ref_mem[a] = prog_data;
            end
            gen_seq($urandom_range(0, 40));
            build(len);
            run(-1, 1'b0, dseen);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
